// File: rtl/receiver.sv
// ----------------------------------------------------------------------------
// receiver
//   UART 8N1 receive side (start 0, 8 data bits LSB first, stop 1, idle high).
//   Recovers bytes from the asynchronous serial line and presents each good
//   byte with a one-cycle valid strobe. WAIT clocks per bit, WAIT >= 4.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   uart_rx    in   serial line, asynchronous to clk, idle high
//   data       out  [7:0] last correctly received byte, held until next good frame
//   valid      out  one-cycle pulse when data is updated
//   busy       out  high while a frame (or a line break) is in progress
//   frame_err  out  one-cycle pulse when the stop bit samples 0
// ----------------------------------------------------------------------------
module receiver #(
   parameter int unsigned WAIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       busy,
   output logic       frame_err
);

   localparam int unsigned CW = $clog2(WAIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(WAIT/2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      shift_q;
   logic [7:0]      data_q;
   logic            valid_q;
   logic            busy_q;
   logic            ferr_q;
   logic            sync1_q;
   logic            sync2_q;
   logic            rx_s;

   // Two-flop synchronizer, preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         cnt_q   <= cnt_q + CW'(1);
         case (state_q)
            S_IDLE: begin
               busy_q <= 1'b0;
               if (!rx_s) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               // Mid start bit: a high line here was only a glitch.
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q <= S_DATA;
                     idx_q   <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               // Counter restarts per bit so every sample lands mid-bit.
               if (cnt_q == BIT_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (cnt_q == BIT_M1) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               // Hold off until the line returns high so a break cannot retrigger.
               if (rx_s) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_receiver.sv
// ----------------------------------------------------------------------------
// tb_receiver
//   Self-checking bench for receiver at WAIT=16. Frames are generated
//   bit-by-bit; a reference model predicts each frame's outcome (valid with
//   byte, or frame_err with the last good byte held) and its latency.
// ----------------------------------------------------------------------------
module tb_receiver;

   localparam int unsigned WAIT = 16;
   localparam int LAT = 2 + WAIT/2 + 9*WAIT + 1;

   typedef struct {
      int         kind;   // 1 = valid, 2 = frame_err
      logic [7:0] d;
      int         cyc;
   } ev_t;

   logic       clk;
   logic       reset;
   logic       uart_rx;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;

   int n_chk;
   int n_fail;
   int cyc;
   int busy_rises;
   logic busy_prev;
   logic [7:0] last_good;

   ev_t expq[$];
   ev_t obsq[$];

   receiver #(.WAIT(WAIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .data      (data),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs away from the active edge.
   initial begin
      busy_rises = 0;
      busy_prev  = 1'b0;
   end
   always @(negedge clk) begin
      ev_t e;
      if (valid) begin
         e.kind = 1; e.d = data; e.cyc = cyc;
         obsq.push_back(e);
      end
      if (frame_err) begin
         e.kind = 2; e.d = data; e.cyc = cyc;
         obsq.push_back(e);
      end
      if (busy && !busy_prev) busy_rises = busy_rises + 1;
      busy_prev = busy;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame; the model records the outcome the line rules imply.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      ev_t e;
      bits = {stop, d, 1'b0};
      e.cyc = cyc;
      if (stop) begin
         e.kind = 1; e.d = d; last_good = d;
      end else begin
         e.kind = 2; e.d = last_good;
      end
      expq.push_back(e);
      uart_rx = 1'b0;
      tick(5);
      check_val("busy_after_start", {31'd0, busy}, 32'd1);
      tick(WAIT - 5);
      for (int i = 1; i < 10; i++) begin
         uart_rx = bits[i];
         tick(WAIT);
      end
   endtask

   task automatic check_batch(input string tag);
      int n;
      int diff;
      tick(3 * WAIT);
      check_val({tag, "_nevents"}, obsq.size(), expq.size());
      n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
      for (int i = 0; i < n; i++) begin
         diff = obsq[i].cyc - expq[i].cyc;
         check_val({tag, "_kind"}, obsq[i].kind, expq[i].kind);
         check_val({tag, "_data"}, {24'd0, obsq[i].d}, {24'd0, expq[i].d});
         check_val({tag, "_latency_in_window"},
                   {31'd0, (diff >= LAT - 2 && diff <= LAT + 2)}, 32'd1);
      end
      obsq.delete();
      expq.delete();
      check_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rs;
      int         rises0;
      n_chk     = 0;
      n_fail    = 0;
      last_good = 8'h00;
      reset     = 1'b0;
      uart_rx   = 1'b1;

      // Reset held: outputs stay at reset values whatever the line does.
      tick(2);
      for (int i = 0; i < 12; i++) begin
         uart_rx = 1'($urandom);
         tick(1);
         check_val("reset_outputs", {20'd0, data, valid, busy, frame_err}, 32'd0);
      end
      uart_rx = 1'b1;
      tick(2);
      reset = 1'b1;
      check_batch("post_reset_quiet");
      check_val("post_reset_data", {24'd0, data}, 32'd0);

      // Single byte.
      send_frame(8'h5A, 1'b1);
      check_batch("single_5A");

      // Back-to-back pair, no idle gap.
      send_frame(8'h5A, 1'b1);
      send_frame(8'hA5, 1'b1);
      check_batch("b2b_5A_A5");

      // Glitch shorter than half a bit.
      rises0 = busy_rises;
      uart_rx = 1'b0;
      tick(3);
      uart_rx = 1'b1;
      check_batch("glitch");
      check_val("glitch_busy_pulsed", {31'd0, busy_rises > rises0}, 32'd1);

      // Framing error followed by a held break.
      send_frame(8'hFF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(WAIT);
         check_val("break_busy_held", {31'd0, busy}, 32'd1);
      end
      uart_rx = 1'b1;
      tick(6);
      check_val("break_released", {31'd0, busy}, 32'd0);
      send_frame(8'h3C, 1'b1);
      check_batch("ferr_then_3C");

      // Reset in the middle of data bit 4.
      uart_rx = 1'b0;
      tick(WAIT);
      rb = 8'hC3;
      for (int i = 0; i < 4; i++) begin
         uart_rx = rb[i];
         tick(WAIT);
      end
      uart_rx = rb[4];
      tick(WAIT/2);
      reset = 1'b0;
      #1;
      check_val("midframe_reset_outputs", {20'd0, data, valid, busy, frame_err}, 32'd0);
      tick(3);
      uart_rx = 1'b1;
      tick(2);
      reset = 1'b1;
      last_good = 8'h00;
      check_batch("aborted_frame");
      check_val("aborted_data", {24'd0, data}, 32'd0);
      send_frame(8'hC3, 1'b1);
      check_batch("after_reset_C3");

      // Randomized frames with random gaps and occasional framing errors.
      for (int i = 0; i < 10; i++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 4) != 0);
         send_frame(rb, rs);
         if (!rs) begin
            uart_rx = 1'b0;
            tick($urandom_range(0, WAIT));
            uart_rx = 1'b1;
            tick(4);
         end
         tick($urandom_range(0, 6));
      end
      check_batch("random");
      check_val("random_final_data", {24'd0, data}, {24'd0, last_good});

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
UART receive side, the counterpart of the existing transmitter. It uses the same 8N1 frame and the same WAIT clocks-per-bit timing: start bit 0, 8 data bits LSB first, stop bit 1, idle line high. It recovers bytes from the asynchronous uart_rx line and presents each byte with a one-cycle valid strobe to core logic. It is the loopback partner for the transmitter in unit and system benches.

Parameters:
WAIT, 868, clock cycles per UART bit; must be >= 4. Tests use WAIT=16, the same value the transmitter bench uses.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
uart_rx  input  1  serial line, asynchronous to clk, idle high
data  output  8  last correctly received byte; held until the next good frame
valid  output  1  one-cycle pulse when data is updated
busy  output  1  1 while a frame is being received
frame_err  output  1  one-cycle pulse when the stop bit samples 0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data=8'h00, valid=0, busy=0, frame_err=0, counters=0. Synchronizer flops preset to 1 so no false start occurs.
- Input sync: uart_rx passes through 2 flops to give rx_s (2-cycle latency). All decisions use rx_s only.
- Bit counter cnt: width $clog2(WAIT). Reset to 0 on every state change. Otherwise increments each cycle.
- Bit index idx: 3 bits.
- IDLE: busy=0. When rx_s==0, go to START with cnt=0.
- START: at cnt==WAIT/2-1 (mid start bit), sample rx_s.
  - rx_s==0: go to DATA, cnt=0, idx=0.
  - rx_s==1: glitch. Return to IDLE with no valid and no frame_err.
- DATA: at cnt==WAIT-1 (mid bit), shift rx_s into the shift register MSB side, right-shifting so the LSB arrives first. idx++. After the sample with idx==7, go to STOP.
- STOP: at cnt==WAIT-1, sample rx_s.
  - rx_s==1: data<=shift register, valid=1 for exactly one cycle (the cycle after the sample edge). Go to IDLE.
  - rx_s==0: frame_err=1 for one cycle, data unchanged, no valid. Go to BREAK.
- BREAK: busy=1. Wait until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering START.
- busy: 1 in START, DATA, STOP and BREAK. It falls in the same cycle valid or frame_err rises, except after frame_err, where busy falls when BREAK exits.
- Back-to-back frames: the next start bit is accepted starting the cycle after valid. No idle gap is required beyond the stop bit's second half.
- Latency: valid rises about 2 + WAIT/2 + 9*WAIT + 1 cycles after the uart_rx falling edge. The bench checks a window of ±2 cycles.
- Reset mid-frame: abort immediately and take reset values. A partial byte is never reported.
- No backpressure: the consumer must take data when valid pulses. data stays stable until the next valid.

Test Plan:
- Reset values: hold reset=0, toggle uart_rx -> data=8'h00, valid=0, busy=0, frame_err=0 throughout. After release with line high, there is no activity.
- Single byte: drive an 8N1 frame of 8'h5A at WAIT=16 -> exactly one valid pulse with data=8'h5A, frame_err never 1. busy is 1 from about 3 cycles after the start edge until valid.
- Loopback: connect transmitter.uart_tx to uart_rx and send 8'h5A, then 8'hA5, back-to-back -> two valid pulses with data 8'h5A then 8'hA5, no frame_err.
- Glitch rejection: pull uart_rx low for 3 cycles (< WAIT/2) then return high -> busy pulses briefly, no valid, no frame_err, state back to IDLE.
- Framing error / break: send 8'hFF with stop bit 0, then hold the line low for 3*WAIT before releasing.
  - Expected: one frame_err pulse, no valid, data keeps its previous value, busy stays 1 until the line returns high.
  - A subsequent 8'h3C frame is then received correctly.
- Reset mid-frame: assert reset during data bit 4 of a frame, release, then send 8'hC3.
  - Expected: no output for the aborted frame.
  - Then one valid with data=8'hC3.
